crclut: RTL and testbench
=========================

CRCLUT -- requirements
Module: crclut

Interface
- REQ-001: Parameter XN, default 0, meaning bit-offset exponent of the 8-bit input slice within the CRC-32 message; legal range 0..4095.
- REQ-002: clk  input  1  rising-edge clock; used only when the output register is compiled in.
- REQ-003: rst  input  1  reset, synchronous, active-high; used only when the output register is compiled in.
- REQ-004: addr  input  8  input byte slice to be mapped.
- REQ-005: data  output  32  CRC-32 partial remainder contributed by addr.

Function
- REQ-006: Generator polynomial SHALL be CRC-32 G(x)=0x104C11DB7 (normal form, x^32 implicit).
- REQ-007: Define R(n) = x^n mod G(x), a 31-degree-max polynomial.
- REQ-008: addr bit k (k=0..7) SHALL represent the message term x^(XN+39-k).
- REQ-009: data SHALL equal the XOR over all k with addr[k]=1 of R(XN+39-k); addr=0 gives data=0.
- REQ-010: Output bit ordering SHALL be reflected: data[i] is the coefficient of x^(31-i).
- REQ-011: Mapping SHALL be linear over GF(2): data(a^b) = data(a) ^ data(b) for all a, b.
- REQ-012: The 256-entry table SHALL be computed at elaboration from XN (constant function or generate); no runtime state, no external table files.
- REQ-013: Without the output register, data SHALL be purely combinational from addr (zero latency, no clock dependence).
- REQ-014: With the output register, data SHALL reflect addr sampled at the previous rising clk edge (latency 1), updating every cycle.
- REQ-015: Multiple instances with different XN SHALL be independent; XN SHALL be the only per-instance difference.

Reset
- REQ-016: With the output register, rst=1 at a rising edge SHALL force data to 32'h00000000 on that edge, taking priority over addr.
- REQ-017: Reset asserted mid-stream SHALL discard the registered value; the first post-reset edge with rst=0 SHALL load the mapping of the then-current addr.
- REQ-018: Without the output register, rst SHALL have no effect.

Configuration
- REQ-019: Macro CRCLUT_OUTREG_EN SHALL compile in the output register (REQ-014, REQ-016, REQ-017).
- REQ-020: Without CRCLUT_OUTREG_EN, the block SHALL be combinational (REQ-013), with clk and rst present but unused.
- REQ-021: The port list SHALL be identical in both builds.

Verification
- REQ-022: XN=0, addr=8'h00 -> data=32'h00000000.
- REQ-023: XN=0, addr=8'h80 -> data=32'hEDB88320 (R(32) reflected); addr=8'h40 -> data=32'h76DC4190.
- REQ-024: XN=0, addr=8'hC0 -> data=32'h9B64C2B0 (linearity check); exhaustive sweep of all 256 addr for XN in {0,8,32,56} against a bitwise software polynomial model.
- REQ-025: CRCLUT_OUTREG_EN build: addr=8'h80 applied before edge N -> data=32'hEDB88320 after edge N, not before.
- REQ-026: CRCLUT_OUTREG_EN build: rst=1 on an edge while addr=8'h80 -> data=0; rst drops -> 32'hEDB88320 on the next edge.

Source files
------------

// File: rtl/crclut.sv
// ---------------------------------------------------------------------------
// crclut -- CRC-32 byte-slice lookup table
//
// Maps an 8-bit message slice to the CRC-32 partial remainder that slice
// contributes. The slice sits at bit offset XN in the message, so addr[k]
// stands for the term x^(XN+39-k). The generator is
// G(x) = 0x104C11DB7 (normal form). The result is bit-reflected, so data[i]
// holds the coefficient of x^(31-i). The mapping is linear over GF(2):
// each addr bit selects one basis remainder, and the selected ones are XORed.
//
// The 256-entry table is built at elaboration from XN by constant functions.
// Nothing about it changes at run time.
//
// Parameters
//   XN    bit-offset exponent of the slice, 0..4095
//
// Ports
//   clk   in   1   rising-edge clock, used only with the output register
//   rst   in   1   synchronous active-high reset, used only with the
//                  output register
//   addr  in   8   message byte slice
//   data  out  32  reflected partial remainder for addr
//
// Configuration macro
//   CRCLUT_OUTREG_EN  defined   : data is registered (latency 1). rst=1 on
//                                 an edge clears data and overrides addr.
//                     undefined : data is combinational from addr.
//                                 clk and rst are present but ignored.
// The port list is the same in both builds.
// ---------------------------------------------------------------------------
module crclut #(
  parameter int unsigned XN = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  addr,
  output logic [31:0] data
);

  // x^32 reduces to these low 32 bits of G(x)
  localparam logic [31:0] POLY = 32'h04C11DB7;

  // Multiply a reduced polynomial by x, then reduce modulo G.
  function automatic logic [31:0] mul_x(input logic [31:0] r);
    logic [31:0] s;
    s = {r[30:0], 1'b0};
    if (r[31]) s = s ^ POLY;
    return s;
  endfunction

  // Compute a*b mod G with shift-and-add, taking bits of b from the MSB down.
  function automatic logic [31:0] mul_mod(input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      r = mul_x(r);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  // Compute x^n mod G by square-and-multiply.
  // This keeps every elaboration loop short even when XN is large.
  function automatic logic [31:0] pow_x(input int unsigned n);
    logic [31:0] result;
    logic [31:0] base;
    logic [15:0] e;
    result = 32'h0000_0001;
    base   = 32'h0000_0002;
    e      = n[15:0];
    for (int i = 0; i < 16; i++) begin
      if (e[i]) result = mul_mod(result, base);
      base = mul_mod(base, base);
    end
    return result;
  endfunction

  // Reverse the bit order: normal form to reflected form.
  function automatic logic [31:0] reflect32(input logic [31:0] r);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 32; i++) o[i] = r[31-i];
    return o;
  endfunction

  // Basis remainders, already reflected. Entry k is the remainder for addr[k].
  // addr[7] is the lowest exponent, XN+32. Each lower bit index is one
  // power of x higher.
  function automatic logic [7:0][31:0] calc_basis(input int unsigned xn);
    logic [7:0][31:0] b;
    logic [31:0]      r;
    b = '0;
    r = pow_x(xn + 32);
    for (int k = 7; k >= 0; k--) begin
      b[k] = reflect32(r);
      r    = mul_x(r);
    end
    return b;
  endfunction

  // Full table: each entry is the XOR of the basis values its bits select.
  function automatic logic [255:0][31:0] build_table(input logic [7:0][31:0] b);
    logic [255:0][31:0] t;
    logic [7:0]         a;
    logic [31:0]        e;
    t = '0;
    for (int i = 0; i < 256; i++) begin
      a = i[7:0];
      e = '0;
      for (int k = 0; k < 8; k++) begin
        if (a[k]) e = e ^ b[k];
      end
      t[i] = e;
    end
    return t;
  endfunction

  localparam logic [7:0][31:0]   BASIS = calc_basis(XN);
  localparam logic [255:0][31:0] TABLE = build_table(BASIS);

  logic [31:0] lut_out;
  assign lut_out = TABLE[addr];

`ifdef CRCLUT_OUTREG_EN
  // Reset wins over addr. The first edge after reset releases loads the
  // mapping of whatever addr is present on that edge.
  always_ff @(posedge clk) begin
    if (rst) data <= '0;
    else     data <= lut_out;
  end
`else
  // Purely combinational build. clk and rst stay on the port list only so
  // that both builds share one interface.
  assign data = lut_out;

  logic unused;
  assign unused = &{1'b0, clk, rst};
`endif

endmodule

// File: tb/tb_crclut.sv
// ---------------------------------------------------------------------------
// tb_crclut -- self-checking bench for crclut
//
// Four instances with XN = 0, 8, 32, 56 are driven from one shared addr.
// Expected values come from a bit-serial long-division model of the message
// polynomial. They are pushed to exp_q when stimulus is driven and popped
// when the outputs are valid. Fixed reference constants and the reset
// behaviour are checked directly. The bench works with or without
// CRCLUT_OUTREG_EN.
// ---------------------------------------------------------------------------
module tb_crclut;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] addr = 8'h00;
  always #5 clk = ~clk;

  logic [31:0] data0, data8, data32, data56;

  crclut #(.XN(0))  u_xn0  (.clk(clk), .rst(rst), .addr(addr), .data(data0));
  crclut #(.XN(8))  u_xn8  (.clk(clk), .rst(rst), .addr(addr), .data(data8));
  crclut #(.XN(32)) u_xn32 (.clk(clk), .rst(rst), .addr(addr), .data(data32));
  crclut #(.XN(56)) u_xn56 (.clk(clk), .rst(rst), .addr(addr), .data(data56));

  // ---------------- scoreboard ----------------
  logic [127:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model: feed the message bits MSB first through a division
  // register, so the register ends holding M(x) mod G. Then reflect it.
  function automatic logic [31:0] model(input int xn, input logic [7:0] a);
    logic [31:0] rem;
    logic [31:0] out;
    logic        fb;
    logic        b;
    rem = '0;
    for (int p = xn + 39; p >= 0; p--) begin
      if (p >= xn + 32) b = a[xn + 39 - p];
      else              b = 1'b0;
      fb  = rem[31];
      rem = {rem[30:0], b};
      if (fb) rem = rem ^ POLY;
    end
    for (int i = 0; i < 32; i++) out[i] = rem[31-i];
    return out;
  endfunction

  // ---------------- driver ----------------
  task automatic apply(input logic [7:0] a);
    logic [127:0] e;
    @(negedge clk);
    addr = a;
    exp_q.push_back({model(56, a), model(32, a), model(8, a), model(0, a)});
`ifdef CRCLUT_OUTREG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'h1, 32'h0);
    end else begin
      e = exp_q.pop_front();
      check("xn0",  data0,  e[31:0]);
      check("xn8",  data8,  e[63:32]);
      check("xn32", data32, e[95:64]);
      check("xn56", data56, e[127:96]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst  = 1'b1;
    addr = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_data", data0, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;

    // reference constants
    apply(8'h00); check("c_00", data0, 32'h0000_0000);
    apply(8'h80); check("c_80", data0, 32'hEDB8_8320);
    apply(8'h40); check("c_40", data0, 32'h76DC_4190);
    apply(8'hC0); check("c_C0", data0, 32'h9B64_C2B0);

    // exhaustive sweep of every addr
    for (int a = 0; a < 256; a++) apply(a[7:0]);

    // random stimulus
    for (int i = 0; i < 64; i++) apply(8'($urandom_range(0, 255)));

`ifdef CRCLUT_OUTREG_EN
    // reset has priority over addr
    @(negedge clk);
    addr = 8'h80;
    rst  = 1'b1;
    @(posedge clk); #1;
    check("rst_prio", data0, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("not_before_edge", data0, 32'h0000_0000);
    @(posedge clk); #1;
    check("load_after_rst", data0, 32'hEDB8_8320);
    // reset in the middle of a stream discards the held value
    @(negedge clk);
    addr = 8'h40;
    #1;
    check("latency_hold", data0, 32'hEDB8_8320);
    @(posedge clk); #1;
    check("latency_load", data0, 32'h76DC_4190);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midstream_rst", data0, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_load", data0, 32'h76DC_4190);
`else
    // reset has no effect on the combinational build
    @(negedge clk);
    rst  = 1'b1;
    addr = 8'h80;
    #1;
    check("rst_ignored", data0, 32'hEDB8_8320);
    @(posedge clk); #1;
    check("rst_ignored_edge", data0, 32'hEDB8_8320);
    @(negedge clk);
    rst = 1'b0;
`endif

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
